rv32v_vreg_file_banked: RTL

Parametrised vector register file for the RV32V pipeline: NUM_REGS registers of VLEN bits, read and written NUM_LANES elements per cycle at SEW 8/16/32. Adds what the fixed-width file lacks:
- LMUL register-group crossing
- vl-based lane masking
- registered read ports with write-first bypass
- mask-bit writes
- post-reset clear sequencer

Sits between vector decode (two read ports) and vector writeback (one write port).

---
 rtl/rv32v_vreg_file_banked.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rv32v_vreg_file_banked.sv
// Banked RV32V vector register file: multi-lane SEW 8/16/32 access with LMUL group crossing,
// vl lane masking, registered write-first read ports, mask-bit writes and a post-reset clear sequencer.
module rv32v_vreg_file_banked #(
  parameter int NUM_LANES = 2,
  parameter int VLEN      = 128,
  parameter int NUM_REGS  = 32,
  parameter int OFF_W     = $clog2(VLEN) + 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   ready,
  input  logic [1:0]             de_sew,
  input  logic [OFF_W-1:0]       de_vl,
  input  logic [4:0]             vs1,
  input  logic [4:0]             vs2,
  input  logic [OFF_W-1:0]       vs1_offset,
  input  logic [OFF_W-1:0]       vs2_offset,
  output logic [NUM_LANES*32-1:0] vs1_data,
  output logic [NUM_LANES*32-1:0] vs2_data,
  output logic [NUM_LANES-1:0]   vs1_active,
  output logic [NUM_LANES-1:0]   vs2_active,
  input  logic [1:0]             wb_sew,
  input  logic [OFF_W-1:0]       wb_vl,
  input  logic                   wen,
  input  logic                   write_single_bit,
  input  logic [4:0]             vd,
  input  logic [OFF_W-1:0]       vd_offset,
  input  logic [NUM_LANES-1:0]   lane_en,
  input  logic [NUM_LANES*32-1:0] w_data
);
  localparam int VBYTES = VLEN / 8;
  localparam int BB     = $clog2(VBYTES);
  localparam int VB     = $clog2(VLEN);
  localparam int RW     = $clog2(NUM_REGS);
  localparam int EW     = OFF_W + 4;
  localparam int AW     = EW + 2;
  localparam int SW     = AW + 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_reg;
  logic            ready_reg;
  logic [RW-1:0]   clr_cnt_reg;
  logic [7:0]      mem [NUM_REGS][VBYTES];

  function automatic logic [1:0] sew_shift(input logic [1:0] sew);
    return (sew == 2'd0) ? 2'd0 : (sew == 2'd1) ? 2'd1 : 2'd2;
  endfunction

  // Register group crossing: whole-register byte overflow advances the register number.
  function automatic logic [RW-1:0] reg_of(input logic [4:0] base, input logic [AW-1:0] baddr);
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(baddr >> BB);
    return RW'(sum % SW'(NUM_REGS));
  endfunction

  logic [1:0] w_sh, r_sh;
  logic [2:0] w_nb, r_nb;
  assign w_sh = sew_shift(wb_sew);
  assign r_sh = sew_shift(de_sew);
  assign w_nb = 3'd1 << w_sh;
  assign r_nb = 3'd1 << r_sh;

  logic [NUM_LANES-1:0][RW-1:0] w_reg;
  logic [NUM_LANES-1:0][BB-1:0] w_byte;
  logic [NUM_LANES-1:0][BB-1:0] m_byte;
  logic [NUM_LANES-1:0][2:0]    m_bit;
  logic [NUM_LANES-1:0]         w_go;
  logic [RW-1:0]                m_reg;
  assign m_reg = reg_of(vd, '0);

  genvar gi, pi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_wlane
      logic [EW-1:0] e;
      logic [AW-1:0] ba;
      assign e           = EW'(vd_offset) + EW'(gi);
      assign ba          = AW'(e) << w_sh;
      assign w_reg[gi]   = reg_of(vd, ba);
      assign w_byte[gi]  = ba[BB-1:0];
      // Mask layout ignores SEW: bit index is the element index mod VLEN.
      assign m_byte[gi]  = e[VB-1:3];
      assign m_bit[gi]   = e[2:0];
      assign w_go[gi]    = wen & lane_en[gi] & (e < EW'(wb_vl)) & ready_reg;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == RW'(NUM_REGS - 1)) begin
            state_reg <= READY;
            ready_reg <= 1'b1;
          end
        end
        default: ready_reg <= 1'b1;
      endcase
    end
  end

  assign ready = ready_reg;

  // Later lanes are assigned last, so the higher lane wins on overlapping mask bits.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_reg == CLEAR) begin
        for (int k = 0; k < VBYTES; k++) mem[clr_cnt_reg][k] <= '0;
      end else begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (w_go[l]) begin
            if (write_single_bit) begin
              mem[m_reg][m_byte[l]][m_bit[l]] <= w_data[l*32];
            end else begin
              for (int kk = 0; kk < 4; kk++)
                if (kk < int'(w_nb))
                  mem[w_reg[l]][w_byte[l] + BB'(kk)] <= w_data[l*32 + 8*kk +: 8];
            end
          end
        end
      end
    end
  end

  generate
    for (pi = 0; pi < 2; pi++) begin : g_port
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_rlane
        logic [4:0]       base;
        logic [OFF_W-1:0] off;
        logic [EW-1:0]    e;
        logic [AW-1:0]    ba;
        logic [RW-1:0]    r_reg;
        logic [BB-1:0]    r_byte;
        logic             act;
        logic [31:0]      val;
        logic [31:0]      data_reg;
        logic             active_reg;

        assign base   = (pi == 0) ? vs1 : vs2;
        assign off    = (pi == 0) ? vs1_offset : vs2_offset;
        assign e      = EW'(off) + EW'(gi);
        assign ba     = AW'(e) << r_sh;
        assign r_reg  = reg_of(base, ba);
        assign r_byte = ba[BB-1:0];
        assign act    = e < EW'(de_vl);

        // Each byte is overlaid with any same-cycle write to it, giving write-first reads.
        always_comb begin
          logic [7:0]    byt;
          logic [BB-1:0] rb;
          byt = '0;
          rb  = '0;
          val = '0;
          for (int k = 0; k < 4; k++) begin
            if (k < int'(r_nb)) begin
              rb  = r_byte + BB'(k);
              byt = mem[r_reg][rb];
              for (int l = 0; l < NUM_LANES; l++) begin
                if (w_go[l] && write_single_bit) begin
                  if (m_reg == r_reg && m_byte[l] == rb) byt[m_bit[l]] = w_data[l*32];
                end else if (w_go[l]) begin
                  for (int kk = 0; kk < 4; kk++)
                    if (kk < int'(w_nb) && w_reg[l] == r_reg && (w_byte[l] + BB'(kk)) == rb)
                      byt = w_data[l*32 + 8*kk +: 8];
                end
              end
              val[8*k +: 8] = byt;
            end
          end
        end

        always_ff @(posedge CLK) begin
          if (RST || state_reg != READY) begin
            data_reg   <= '0;
            active_reg <= 1'b0;
          end else begin
            data_reg   <= act ? val : '0;
            active_reg <= act;
          end
        end

        if (pi == 0) begin : g_o1
          assign vs1_data[gi*32 +: 32] = data_reg;
          assign vs1_active[gi]        = active_reg;
        end else begin : g_o2
          assign vs2_data[gi*32 +: 32] = data_reg;
          assign vs2_active[gi]        = active_reg;
        end
      end
    end
  endgenerate
endmodule
